uart_fifo_regs: RTL and testbench

Parameterised UART data register bank: CPU-facing register interface to a TX queue and an RX queue of configurable width and depth. Sits between the bus/CPU and the UART transmitter/receiver cores. Adds status, sticky overflow flags, flush control and an RX interrupt that the single-entry data registers lack.

---
 rtl/uart_regs_pkg.sv | 29 ++
 rtl/sync_fifo.sv | 59 +++++
 rtl/uart_fifo_regs.sv | 127 ++++++++++++
 tb/tb_uart_fifo_regs.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_regs_pkg.sv
// Shared register map for the UART FIFO register bank: bus addresses and
// bit positions inside the STATUS and CTRL registers.
package uart_regs_pkg;

  typedef enum logic [1:0] {
    ADDR_TXDATA = 2'd0,
    ADDR_RXDATA = 2'd1,
    ADDR_STATUS = 2'd2,
    ADDR_CTRL   = 2'd3
  } reg_addr_e;

  // STATUS bit positions
  localparam int unsigned ST_TX_EMPTY = 0;
  localparam int unsigned ST_TX_FULL  = 1;
  localparam int unsigned ST_RX_EMPTY = 2;
  localparam int unsigned ST_RX_FULL  = 3;
  localparam int unsigned ST_TX_OVF   = 4;
  localparam int unsigned ST_RX_OVF   = 5;
  localparam int unsigned ST_IRQ_EN   = 6;
  localparam int unsigned ST_TX_CNT   = 8;
  localparam int unsigned ST_RX_CNT   = 16;

  // CTRL bit positions
  localparam int unsigned CTRL_FLUSH_TX = 0;
  localparam int unsigned CTRL_FLUSH_RX = 1;
  localparam int unsigned CTRL_CLR_OVF  = 2;
  localparam int unsigned CTRL_IRQ_EN   = 3;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with push/pop/flush, occupancy count and full/empty.
// A pop on a full FIFO frees the slot for a same-cycle push; a push on an
// empty FIFO is never bypassed to the output. Flush wins over push and pop.
module sync_fifo #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic              clk,
  input  logic              rst_i,
  input  logic              push,
  input  logic              pop,
  input  logic              flush,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty,
  output logic [CNT_W-1:0]  count
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  rptr;
  logic [PTR_W-1:0]  wptr;
  logic [CNT_W-1:0]  cnt;
  logic              do_push;
  logic              do_pop;

  assign empty   = (cnt == '0);
  assign full    = (cnt == CNT_W'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Pointer and occupancy bookkeeping; reset and flush both empty the queue
  always_ff @(posedge clk) begin
    if (rst_i || flush) begin
      rptr <= '0;
      wptr <= '0;
      cnt  <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage write; contents are not reset, the empty gate below hides them
  always_ff @(posedge clk) begin
    if (do_push && !flush && !rst_i) mem[wptr] <= din;
  end

  assign dout  = empty ? '0 : mem[rptr];
  assign count = cnt;

endmodule

// File: rtl/uart_fifo_regs.sv
// CPU register bank in front of the UART TX and RX queues: TXDATA push,
// RXDATA pop-on-read, STATUS, CTRL (flush / overflow clear / irq enable),
// sticky overflow flags and the RX interrupt.
module uart_fifo_regs
  import uart_regs_pkg::*;
#(
  parameter int unsigned ANCHO  = 32,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_i,
  input  logic [1:0]        addr_i,
  input  logic              we_i,
  input  logic              re_i,
  input  logic [ANCHO-1:0]  wdata_i,
  output logic [ANCHO-1:0]  rdata_o,
  output logic [DATA_W-1:0] tx_data_o,
  output logic              tx_valid_o,
  input  logic              tx_ready_i,
  input  logic [DATA_W-1:0] rx_data_i,
  input  logic              rx_valid_i,
  output logic              irq_o
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  reg_addr_e          addr;
  logic               tx_push, tx_pop, tx_flush, tx_full, tx_empty;
  logic               rx_pop, rx_flush, rx_full, rx_empty;
  logic [CNT_W-1:0]   tx_count, rx_count;
  logic [DATA_W-1:0]  rx_head;
  logic               ctrl_wr, clr_ovf;
  logic               tx_ovf_set, rx_ovf_set;
  logic               tx_ovf, rx_ovf, irq_en;

  assign addr     = reg_addr_e'(addr_i);
  assign ctrl_wr  = we_i && (addr == ADDR_CTRL);
  assign tx_flush = ctrl_wr && wdata_i[CTRL_FLUSH_TX];
  assign rx_flush = ctrl_wr && wdata_i[CTRL_FLUSH_RX];
  assign clr_ovf  = ctrl_wr && wdata_i[CTRL_CLR_OVF];

  assign tx_push  = we_i && (addr == ADDR_TXDATA);
  assign tx_pop   = tx_valid_o && tx_ready_i;
  assign rx_pop   = re_i && (addr == ADDR_RXDATA);

  // A push into a full queue is only lost when no pop frees a slot that
  // cycle, and a flush swallows the push without counting it as overflow.
  assign tx_ovf_set = tx_push && tx_full && !tx_pop && !tx_flush;
  assign rx_ovf_set = rx_valid_i && rx_full && !rx_pop && !rx_flush;

  sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_tx_fifo (
    .clk   (clk),
    .rst_i (rst_i),
    .push  (tx_push),
    .pop   (tx_pop),
    .flush (tx_flush),
    .din   (wdata_i[DATA_W-1:0]),
    .dout  (tx_data_o),
    .full  (tx_full),
    .empty (tx_empty),
    .count (tx_count)
  );

  sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_rx_fifo (
    .clk   (clk),
    .rst_i (rst_i),
    .push  (rx_valid_i),
    .pop   (rx_pop),
    .flush (rx_flush),
    .din   (rx_data_i),
    .dout  (rx_head),
    .full  (rx_full),
    .empty (rx_empty),
    .count (rx_count)
  );

  assign tx_valid_o = !tx_empty;

  // Sticky overflow flags and stored irq enable; clear wins over a same-cycle set
  always_ff @(posedge clk) begin
    if (rst_i) begin
      tx_ovf <= 1'b0;
      rx_ovf <= 1'b0;
      irq_en <= 1'b0;
    end else begin
      if (clr_ovf) begin
        tx_ovf <= 1'b0;
        rx_ovf <= 1'b0;
      end else begin
        if (tx_ovf_set) tx_ovf <= 1'b1;
        if (rx_ovf_set) rx_ovf <= 1'b1;
      end
      if (ctrl_wr) irq_en <= wdata_i[CTRL_IRQ_EN];
    end
  end

  assign irq_o = irq_en && (!rx_empty || rx_ovf);

  // Read mux, purely combinational from address and registered state
  always_comb begin
    rdata_o = '0;
    case (addr)
      ADDR_RXDATA: rdata_o[DATA_W-1:0] = rx_head;
      ADDR_STATUS: begin
        rdata_o[ST_TX_EMPTY]          = tx_empty;
        rdata_o[ST_TX_FULL]           = tx_full;
        rdata_o[ST_RX_EMPTY]          = rx_empty;
        rdata_o[ST_RX_FULL]           = rx_full;
        rdata_o[ST_TX_OVF]            = tx_ovf;
        rdata_o[ST_RX_OVF]            = rx_ovf;
        rdata_o[ST_IRQ_EN]            = irq_en;
        rdata_o[ST_TX_CNT +: CNT_W]   = tx_count;
        rdata_o[ST_RX_CNT +: CNT_W]   = rx_count;
      end
      ADDR_CTRL:   rdata_o[CTRL_IRQ_EN] = irq_en;
      default:     rdata_o = '0;
    endcase
  end

endmodule

// File: tb/tb_uart_fifo_regs.sv
// Directed self-checking bench for uart_fifo_regs with DEPTH=4, DATA_W=8.
module tb_uart_fifo_regs;

  logic        clk = 1'b0;
  logic        rst_i;
  logic [1:0]  addr_i;
  logic        we_i;
  logic        re_i;
  logic [31:0] wdata_i;
  logic [31:0] rdata_o;
  logic [7:0]  tx_data_o;
  logic        tx_valid_o;
  logic        tx_ready_i;
  logic [7:0]  rx_data_i;
  logic        rx_valid_i;
  logic        irq_o;

  int errors = 0;
  int checks = 0;

  uart_fifo_regs #(
    .ANCHO  (32),
    .DATA_W (8),
    .DEPTH  (4)
  ) dut (
    .clk        (clk),
    .rst_i      (rst_i),
    .addr_i     (addr_i),
    .we_i       (we_i),
    .re_i       (re_i),
    .wdata_i    (wdata_i),
    .rdata_o    (rdata_o),
    .tx_data_o  (tx_data_o),
    .tx_valid_o (tx_valid_o),
    .tx_ready_i (tx_ready_i),
    .rx_data_i  (rx_data_i),
    .rx_valid_i (rx_valid_i),
    .irq_o      (irq_o)
  );

  always #5 clk = ~clk;

  // Advance one clock; inputs are changed and outputs sampled 1ns after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we_i = 1'b0; re_i = 1'b0; addr_i = 2'd2; wdata_i = '0;
    rx_valid_i = 1'b0; rx_data_i = '0; tx_ready_i = 1'b0;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    addr_i = a; wdata_i = d; we_i = 1'b1;
    tick();
    we_i = 1'b0; wdata_i = '0; addr_i = 2'd2;
  endtask

  task automatic peek(input logic [1:0] a, output logic [31:0] v);
    addr_i = a;
    #1;
    v = rdata_o;
    addr_i = 2'd2;
  endtask

  task automatic rx_push(input logic [7:0] d);
    rx_data_i = d; rx_valid_i = 1'b1;
    tick();
    rx_valid_i = 1'b0; rx_data_i = '0;
  endtask

  task automatic test_reset();
    logic [31:0] v;
    idle();
    rst_i = 1'b1;
    tick(); tick();
    rst_i = 1'b0;
    #1;
    peek(2'd2, v);
    checks++; if (v !== 32'h5) begin errors++; $display("FAIL reset_status got=%h exp=%h", v, 32'h5); end
    checks++; if (tx_valid_o !== 1'b0) begin errors++; $display("FAIL reset_tx_valid got=%b exp=0", tx_valid_o); end
    checks++; if (tx_data_o !== 8'h00) begin errors++; $display("FAIL reset_tx_data got=%h exp=00", tx_data_o); end
    checks++; if (irq_o !== 1'b0) begin errors++; $display("FAIL reset_irq got=%b exp=0", irq_o); end
    peek(2'd3, v);
    checks++; if (v !== 32'h0) begin errors++; $display("FAIL reset_ctrl got=%h exp=0", v); end
  endtask

  task automatic test_tx_overflow();
    logic [31:0] v;
    logic [7:0]  exp_d;
    for (int i = 0; i < 5; i++) bus_write(2'd0, 32'h41 + i);
    peek(2'd2, v);
    checks++; if (v !== 32'h0000_0416) begin errors++; $display("FAIL tx_full_status got=%h exp=%h", v, 32'h416); end
    peek(2'd0, v);
    checks++; if (v !== 32'h0) begin errors++; $display("FAIL txdata_read got=%h exp=0", v); end
    for (int i = 0; i < 4; i++) begin
      exp_d = 8'h41 + 8'(i);
      checks++; if (tx_data_o !== exp_d || tx_valid_o !== 1'b1) begin
        errors++; $display("FAIL tx_drain[%0d] got=%h/%b exp=%h/1", i, tx_data_o, tx_valid_o, exp_d);
      end
      tx_ready_i = 1'b1;
      tick();
      tx_ready_i = 1'b0;
    end
    checks++; if (tx_valid_o !== 1'b0) begin errors++; $display("FAIL tx_drained_valid got=%b exp=0", tx_valid_o); end
    bus_write(2'd3, 32'h4);
    peek(2'd2, v);
    checks++; if (v !== 32'h5) begin errors++; $display("FAIL tx_ovf_clear got=%h exp=5", v); end
  endtask

  task automatic test_rx_irq();
    logic [31:0] v;
    bus_write(2'd3, 32'h8);
    peek(2'd3, v);
    checks++; if (v !== 32'h8) begin errors++; $display("FAIL ctrl_read got=%h exp=8", v); end
    checks++; if (irq_o !== 1'b0) begin errors++; $display("FAIL irq_idle got=%b exp=0", irq_o); end
    rx_push(8'h5A);
    checks++; if (irq_o !== 1'b1) begin errors++; $display("FAIL irq_on_push got=%b exp=1", irq_o); end
    peek(2'd2, v);
    checks++; if (v !== 32'h0001_0041) begin errors++; $display("FAIL rx_one_status got=%h exp=%h", v, 32'h10041); end
    addr_i = 2'd1; re_i = 1'b1;
    #1;
    checks++; if (rdata_o !== 32'h0000_005A) begin errors++; $display("FAIL rxdata_read got=%h exp=5a", rdata_o); end
    tick();
    re_i = 1'b0;
    peek(2'd2, v);
    checks++; if (v !== 32'h45) begin errors++; $display("FAIL rx_popped_status got=%h exp=45", v); end
    checks++; if (irq_o !== 1'b0) begin errors++; $display("FAIL irq_after_pop got=%b exp=0", irq_o); end
  endtask

  task automatic test_rx_full_simul();
    logic [31:0] v;
    logic [7:0]  exp_q [5];
    exp_q = '{8'h22, 8'h33, 8'h44, 8'h99, 8'h00};
    rx_push(8'h11); rx_push(8'h22); rx_push(8'h33); rx_push(8'h44);
    peek(2'd2, v);
    checks++; if (v !== 32'h0004_0049) begin errors++; $display("FAIL rx_full_status got=%h exp=%h", v, 32'h40049); end
    addr_i = 2'd1; re_i = 1'b1; rx_data_i = 8'h99; rx_valid_i = 1'b1;
    #1;
    checks++; if (rdata_o !== 32'h11) begin errors++; $display("FAIL rx_simul_read got=%h exp=11", rdata_o); end
    tick();
    re_i = 1'b0; rx_valid_i = 1'b0;
    peek(2'd2, v);
    checks++; if (v !== 32'h0004_0049) begin errors++; $display("FAIL rx_simul_status got=%h exp=%h", v, 32'h40049); end
    for (int i = 0; i < 4; i++) begin
      addr_i = 2'd1; re_i = 1'b1;
      #1;
      checks++; if (rdata_o[7:0] !== exp_q[i]) begin errors++; $display("FAIL rx_order[%0d] got=%h exp=%h", i, rdata_o, exp_q[i]); end
      tick();
      re_i = 1'b0;
    end
  endtask

  task automatic test_empty_read_flush();
    logic [31:0] v;
    addr_i = 2'd1; re_i = 1'b1;
    #1;
    checks++; if (rdata_o !== 32'h0) begin errors++; $display("FAIL rx_empty_read got=%h exp=0", rdata_o); end
    tick();
    re_i = 1'b0;
    peek(2'd2, v);
    checks++; if (v !== 32'h45) begin errors++; $display("FAIL empty_read_status got=%h exp=45", v); end
    bus_write(2'd0, 32'h61); bus_write(2'd0, 32'h62);
    rx_push(8'h01); rx_push(8'h02); rx_push(8'h03); rx_push(8'h04);
    // flush both with a push into the full RX queue in the same cycle
    rx_data_i = 8'h77; rx_valid_i = 1'b1;
    bus_write(2'd3, 32'hB);
    rx_valid_i = 1'b0;
    peek(2'd2, v);
    checks++; if (v !== 32'h45) begin errors++; $display("FAIL flush_status got=%h exp=45", v); end
    checks++; if (irq_o !== 1'b0 || tx_valid_o !== 1'b0) begin errors++; $display("FAIL flush_outputs got=%b%b exp=00", irq_o, tx_valid_o); end
  endtask

  task automatic test_ovf_clear();
    logic [31:0] v;
    for (int i = 0; i < 5; i++) rx_push(8'hA0 + 8'(i));
    peek(2'd2, v);
    checks++; if (v !== 32'h0004_0069) begin errors++; $display("FAIL rx_ovf_status got=%h exp=%h", v, 32'h40069); end
    bus_write(2'd3, 32'hC);
    peek(2'd2, v);
    checks++; if (v !== 32'h0004_0049) begin errors++; $display("FAIL rx_ovf_cleared got=%h exp=%h", v, 32'h40049); end
    rx_data_i = 8'hEE; rx_valid_i = 1'b1;
    bus_write(2'd3, 32'hC);
    rx_valid_i = 1'b0;
    peek(2'd2, v);
    checks++; if (v !== 32'h0004_0049) begin errors++; $display("FAIL clear_beats_set got=%h exp=%h", v, 32'h40049); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] v;
    bus_write(2'd0, 32'h31); bus_write(2'd0, 32'h32); bus_write(2'd0, 32'h33);
    tx_ready_i = 1'b1;
    tick();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0; tx_ready_i = 1'b0;
    peek(2'd2, v);
    checks++; if (v !== 32'h5) begin errors++; $display("FAIL mid_reset_status got=%h exp=5", v); end
    checks++; if (tx_valid_o !== 1'b0 || irq_o !== 1'b0) begin errors++; $display("FAIL mid_reset_outputs got=%b%b exp=00", tx_valid_o, irq_o); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] v;
    logic [7:0]  exp_d;
    for (int i = 0; i < 4; i++) bus_write(2'd0, 32'h51 + i);
    tx_ready_i = 1'b1;
    bus_write(2'd0, 32'h55);
    tx_ready_i = 1'b0;
    peek(2'd2, v);
    checks++; if (v !== 32'h0000_0406) begin errors++; $display("FAIL tx_full_pushpop got=%h exp=%h", v, 32'h406); end
    for (int i = 0; i < 4; i++) begin
      exp_d = 8'h52 + 8'(i);
      checks++; if (tx_data_o !== exp_d) begin errors++; $display("FAIL tx_b2b[%0d] got=%h exp=%h", i, tx_data_o, exp_d); end
      tx_ready_i = 1'b1;
      tick();
      tx_ready_i = 1'b0;
    end
    tx_ready_i = 1'b1;
    bus_write(2'd0, 32'h61);
    checks++; if (tx_data_o !== 8'h61 || tx_valid_o !== 1'b1) begin errors++; $display("FAIL tx_stream0 got=%h/%b exp=61/1", tx_data_o, tx_valid_o); end
    bus_write(2'd0, 32'h62);
    peek(2'd2, v);
    checks++; if (tx_data_o !== 8'h62 || v !== 32'h0000_0104) begin errors++; $display("FAIL tx_stream1 got=%h/%h exp=62/104", tx_data_o, v); end
    tick();
    tx_ready_i = 1'b0;
    checks++; if (tx_valid_o !== 1'b0) begin errors++; $display("FAIL tx_stream_end got=%b exp=0", tx_valid_o); end
  endtask

  initial begin
    rst_i = 1'b1;
    idle();
    test_reset();
    test_tx_overflow();
    test_rx_irq();
    test_rx_full_simul();
    test_empty_read_flush();
    test_ovf_clear();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
